// File: rtl/svi_rr_arbiter_if.sv
// Requester/output bundle for svi_rr_arbiter.
// master drives requests and sees results; slave is the arbiter side.
interface svi_rr_arbiter_if #(
  parameter int N_REQ  = 8,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        i_req;
  logic [N_REQ-1:0]        i_last;
  logic [N_REQ*DATA_W-1:0] i_data;
  logic [N_REQ-1:0]        o_gnt;
  logic [IDX_W-1:0]        o_owner;
  logic                    o_valid;
  logic [DATA_W-1:0]       o_data;
  logic                    o_busy;
  logic [15:0]             o_grant_cnt;

  modport master (
    output i_req, i_last, i_data,
    input  o_gnt, o_owner, o_valid, o_data,
    input  o_busy, o_grant_cnt
  );

  modport slave (
    input  i_req, i_last, i_data,
    output o_gnt, o_owner, o_valid, o_data,
    output o_busy, o_grant_cnt
  );
endinterface

// File: rtl/svi_rr_arbiter.sv
// Round-robin burst arbiter onto one registered output datapath.
// Ports: i_clk, i_rst_n (sync, active-low), bus (slave modport).
module svi_rr_arbiter #(
  parameter int N_REQ    = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  svi_rr_arbiter_if.slave   bus
);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              r_state, w_state;
  logic [IDX_W-1:0]    r_ptr, w_ptr;
  logic [IDX_W-1:0]    r_owner, w_owner;
  logic [HOLD_W-1:0]   r_hold, w_hold;
  logic [N_REQ-1:0]    r_gnt, w_gnt;
  logic                r_valid, w_valid;
  logic [DATA_W-1:0]   r_data, w_data;
  logic                r_busy, w_busy;
  logic [15:0]         r_cnt, w_cnt;

  logic [2*N_REQ-2:0]  w_req2;
  logic [N_REQ-1:0]    w_rot;
  logic [IDX_W-1:0]    w_off;
  logic [IDX_W:0]      w_sum;
  logic [IDX_W-1:0]    w_win;
  logic [IDX_W-1:0]    w_nxt;
  logic                w_own_req;
  logic                w_own_last;
  logic [DATA_W-1:0]   w_own_data;
  logic                w_lim;

  // Rotate requests so bit 0 is the slot at ptr.
  assign w_req2 = {bus.i_req[N_REQ-2:0], bus.i_req};
  assign w_rot  = w_req2[r_ptr +: N_REQ];

  always_comb begin
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
  end

  assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win = (w_sum >= (IDX_W+1)'(N_REQ))
               ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
               : w_sum[IDX_W-1:0];

  assign w_nxt = (r_owner == IDX_W'(N_REQ - 1))
               ? '0 : r_owner + IDX_W'(1);

  assign w_own_req  = bus.i_req[r_owner];
  assign w_own_last = bus.i_last[r_owner];
  assign w_own_data = bus.i_data[r_owner*DATA_W +: DATA_W];
  assign w_lim      = (r_hold == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_owner = r_owner;
    w_hold  = r_hold;
    w_gnt   = r_gnt;
    w_valid = 1'b0;
    w_data  = r_data;
    w_busy  = r_busy;
    w_cnt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (|bus.i_req) begin
          w_state = S_GRANT;
          w_gnt   = N_REQ'(1) << w_win;
          w_owner = w_win;
          w_busy  = 1'b1;
          w_hold  = '0;
          if (r_cnt != 16'hFFFF) w_cnt = r_cnt + 16'd1;
        end
      end
      S_GRANT: begin
        if (w_own_req) begin
          w_valid = 1'b1;
          w_data  = w_own_data;
          w_hold  = r_hold + HOLD_W'(1);
        end
        // Abandon, last beat or hold limit: one release.
        if (!w_own_req || w_own_last || w_lim) begin
          w_state = S_IDLE;
          w_gnt   = '0;
          w_busy  = 1'b0;
          w_hold  = '0;
          w_ptr   = w_nxt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_owner <= w_owner;
      r_hold  <= w_hold;
      r_gnt   <= w_gnt;
      r_valid <= w_valid;
      r_data  <= w_data;
      r_busy  <= w_busy;
      r_cnt   <= w_cnt;
    end
  end

  assign bus.o_gnt       = r_gnt;
  assign bus.o_owner     = r_owner;
  assign bus.o_valid     = r_valid;
  assign bus.o_data      = r_data;
  assign bus.o_busy      = r_busy;
  assign bus.o_grant_cnt = r_cnt;
endmodule

// File: tb/tb_svi_rr_arbiter.sv
// Bench for svi_rr_arbiter: vector table, corner sequences,
// and random traffic against a behavioural model.
module tb_svi_rr_arbiter;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int MH = 4;
  localparam logic [63:0] D0 = 64'h7766554433A51100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  svi_rr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus();

  svi_rr_arbiter #(
    .N_REQ(N), .DATA_W(DW), .MAX_HOLD(MH)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  nm, got, exp, $time);
  endtask

  // Behavioural reference.
  bit       m_busy  = 0;
  int       m_owner = 0;
  int       m_ptr   = 0;
  int       m_beats = 0;
  bit       m_valid = 0;
  logic [7:0] m_data = '0;
  int       m_cnt   = 0;

  task automatic model_edge();
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
      m_valid = 0; m_data = '0; m_cnt = 0;
    end else begin
      m_valid = 0;
      if (!m_busy) begin
        if (bus.i_req != '0) begin
          for (int off = N - 1; off >= 0; off--)
            if (bus.i_req[(m_ptr + off) % N])
              m_owner = (m_ptr + off) % N;
          m_busy = 1;
          m_beats = 0;
          if (m_cnt < 65535) m_cnt++;
        end
      end else begin
        if (bus.i_req[m_owner]) begin
          m_valid = 1;
          m_data = bus.i_data[m_owner*DW +: DW];
          m_beats++;
        end
        if (!bus.i_req[m_owner] ||
            (m_valid && (bus.i_last[m_owner] || m_beats == MH))) begin
          m_busy = 0;
          m_ptr = (m_owner + 1) % N;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] req,
                      input logic [7:0] last,
                      input logic [63:0] d);
    rst_n = r;
    bus.i_req = req;
    bus.i_last = last;
    bus.i_data = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic ex(input string nm, input logic [7:0] g,
                    input logic [2:0] o, input logic v,
                    input logic [7:0] d);
    chk({nm, "_gnt"}, 64'(bus.o_gnt), 64'(g));
    chk({nm, "_owner"}, 64'(bus.o_owner), 64'(o));
    chk({nm, "_valid"}, 64'(bus.o_valid), 64'(v));
    if (v) chk({nm, "_data"}, 64'(bus.o_data), 64'(d));
  endtask

  task automatic cmp_model();
    logic [7:0] eg;
    eg = m_busy ? 8'(1 << m_owner) : 8'h00;
    chk("rnd_gnt", 64'(bus.o_gnt), 64'(eg));
    chk("rnd_owner", 64'(bus.o_owner), 64'(m_owner));
    chk("rnd_valid", 64'(bus.o_valid), 64'(m_valid));
    chk("rnd_data", 64'(bus.o_data), 64'(m_data));
    chk("rnd_busy", 64'(bus.o_busy), 64'(m_busy));
    chk("rnd_cnt", 64'(bus.o_grant_cnt), 64'(m_cnt));
  endtask

  typedef struct {
    logic        rst_n;
    logic [7:0]  req;
    logic [7:0]  last;
    logic [7:0]  gnt;
    logic [2:0]  owner;
    logic        valid;
    logic [7:0]  data;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [63:0] dv;
    logic [7:0]  rq;
    int          s;

    tbl[0]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 8'hFF, 8'h00, 8'h01, 3'd0, 1'b0, 8'h00, 1'b1, 16'd1};
    tbl[4]  = '{1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 8'h04, 8'h00, 8'h04, 3'd2, 1'b0, 8'h00, 1'b1, 16'd2};
    tbl[6]  = '{1'b1, 8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 8'hA5, 1'b1, 16'd2};
    tbl[7]  = '{1'b1, 8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 8'hA5, 1'b1, 16'd2};
    tbl[8]  = '{1'b1, 8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 8'hA5, 1'b1, 16'd2};
    tbl[9]  = '{1'b1, 8'h04, 8'h00, 8'h00, 3'd2, 1'b1, 8'hA5, 1'b0, 16'd2};
    tbl[10] = '{1'b1, 8'h04, 8'h00, 8'h04, 3'd2, 1'b0, 8'hA5, 1'b1, 16'd3};
    tbl[11] = '{1'b1, 8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 8'hA5, 1'b0, 16'd3};

    bus.i_req = '0;
    bus.i_last = '0;
    bus.i_data = '0;
    dv = D0;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst_n, tbl[i].req, tbl[i].last, D0);
      chk($sformatf("v%0d_gnt", i), 64'(bus.o_gnt), 64'(tbl[i].gnt));
      chk($sformatf("v%0d_owner", i), 64'(bus.o_owner), 64'(tbl[i].owner));
      chk($sformatf("v%0d_valid", i), 64'(bus.o_valid), 64'(tbl[i].valid));
      chk($sformatf("v%0d_data", i), 64'(bus.o_data), 64'(tbl[i].data));
      chk($sformatf("v%0d_busy", i), 64'(bus.o_busy), 64'(tbl[i].busy));
      chk($sformatf("v%0d_cnt", i), 64'(bus.o_grant_cnt), 64'(tbl[i].cnt));
    end

    // Round-robin order 0..7 then wrap to 0.
    step(1'b0, 8'h00, 8'h00, D0);
    chk("rr_rst_cnt", 64'(bus.o_grant_cnt), 64'd0);
    for (int g = 0; g < 9; g++) begin
      s = g % N;
      step(1'b1, 8'hFF, 8'hFF, D0);
      ex($sformatf("rr%0d_g", g), 8'(1 << s), 3'(s), 1'b0, 8'h00);
      step(1'b1, 8'hFF, 8'hFF, D0);
      ex($sformatf("rr%0d_b", g), 8'h00, 3'(s), 1'b1, dv[s*8 +: 8]);
    end
    chk("rr_cnt", 64'(bus.o_grant_cnt), 64'd9);

    // Abandon by slot 3, then 3 is skipped in favour of 0.
    step(1'b1, 8'h08, 8'h00, D0); ex("ab_g", 8'h08, 3'd3, 1'b0, 8'h00);
    step(1'b1, 8'h08, 8'h00, D0); ex("ab_b1", 8'h08, 3'd3, 1'b1, 8'h33);
    step(1'b1, 8'h08, 8'h00, D0); ex("ab_b2", 8'h08, 3'd3, 1'b1, 8'h33);
    step(1'b1, 8'h00, 8'h00, D0); ex("ab_rel", 8'h00, 3'd3, 1'b0, 8'h00);
    step(1'b1, 8'h09, 8'h00, D0); ex("ab_next", 8'h01, 3'd0, 1'b0, 8'h00);
    step(1'b1, 8'h00, 8'h00, D0); ex("ab_end", 8'h00, 3'd0, 1'b0, 8'h00);

    // Early last from slot 5, pointer wraps to 0.
    step(1'b1, 8'h21, 8'h00, D0); ex("el_g", 8'h20, 3'd5, 1'b0, 8'h00);
    step(1'b1, 8'h21, 8'h00, D0); ex("el_b1", 8'h20, 3'd5, 1'b1, 8'h55);
    step(1'b1, 8'h21, 8'h20, D0); ex("el_b2", 8'h00, 3'd5, 1'b1, 8'h55);
    step(1'b1, 8'h21, 8'h00, D0); ex("el_next", 8'h01, 3'd0, 1'b0, 8'h00);
    step(1'b1, 8'h00, 8'h00, D0); ex("el_end", 8'h00, 3'd0, 1'b0, 8'h00);

    // Reset in the middle of a slot-1 burst.
    step(1'b1, 8'h02, 8'h00, D0); ex("mr_g", 8'h02, 3'd1, 1'b0, 8'h00);
    step(1'b1, 8'h02, 8'h00, D0); ex("mr_b1", 8'h02, 3'd1, 1'b1, 8'h11);
    step(1'b1, 8'h02, 8'h00, D0); ex("mr_b2", 8'h02, 3'd1, 1'b1, 8'h11);
    step(1'b0, 8'h02, 8'h00, D0); ex("mr_rst", 8'h00, 3'd0, 1'b0, 8'h00);
    chk("mr_rst_data", 64'(bus.o_data), 64'd0);
    chk("mr_rst_busy", 64'(bus.o_busy), 64'd0);
    chk("mr_rst_cnt", 64'(bus.o_grant_cnt), 64'd0);
    step(1'b1, 8'h06, 8'h00, D0); ex("mr_regnt", 8'h02, 3'd1, 1'b0, 8'h00);
    chk("mr_cnt", 64'(bus.o_grant_cnt), 64'd1);
    step(1'b1, 8'h00, 8'h00, D0);

    // Random traffic against the model.
    rq = 8'h00;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0)
        rq = rq ^ 8'(1 << $urandom_range(0, N - 1));
      step(($urandom_range(0, 79) != 0), rq,
           8'($urandom & $urandom),
           {$urandom, $urandom});
      cmp_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
